// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Optional packet lock in the top level is enabled by UART_ARB_PKT_LOCK_EN.
package uart_arb_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int BYTE_W      = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first eligible request above ptr, with wrap.
// Returns a one-hot grant and its index; grant is zero when nothing is eligible.
module uart_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic [NUM_REQ-1:0] mask,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx
);

   logic [NUM_REQ-1:0] eligible;
   logic               found;
   int                 j;

   assign eligible = req & mask;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (!found && eligible[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART byte transmitter among NUM_REQ requesters.
// Define UART_ARB_PKT_LOCK_EN to keep a requester granted until its req_last byte.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W  = BYTE_W,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx_start,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_busy,
   input  logic                      tx_clear_req,
   output logic [ID_W-1:0]           grant_id,
   output logic                      arb_busy
);

   state_t             state, next_state;
   logic [ID_W-1:0]    last_id;
   logic [ID_W-1:0]    pick_id;
   logic [NUM_REQ-1:0] pick_gnt;
   logic [NUM_REQ-1:0] mask;
   logic               accept;

`ifdef UART_ARB_PKT_LOCK_EN
   logic            lock;
   logic [ID_W-1:0] lock_id;

   // While a packet is open only its owner is eligible, even if it stalls.
   assign mask = lock ? (NUM_REQ'(1) << lock_id) : '1;
`else
   logic unused_last;

   assign mask        = '1;
   assign unused_last = ^req_last;
`endif

   uart_rr_pick #(
      .NUM_REQ(NUM_REQ),
      .ID_W   (ID_W)
   ) u_pick (
      .req  (req_valid),
      .ptr  (last_id),
      .mask (mask),
      .grant(pick_gnt),
      .idx  (pick_id)
   );

   always_comb begin
      next_state = state;
      req_ready  = '0;
      tx_start   = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            req_ready = pick_gnt;
            if (|pick_gnt) begin
               accept     = 1'b1;
               next_state = START;
            end
         end
         START: begin
            tx_start = 1'b1;
            if (tx_busy) next_state = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_clear_req) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign arb_busy = (state != IDLE);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Reset leaves last_id at the top index so requester 0 wins the first round.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_data  <= '0;
         grant_id <= '0;
         last_id  <= ID_W'(NUM_REQ - 1);
`ifdef UART_ARB_PKT_LOCK_EN
         lock     <= 1'b0;
         lock_id  <= '0;
`endif
      end else if (accept) begin
         tx_data  <= req_data[DATA_W*pick_id +: DATA_W];
         grant_id <= pick_id;
`ifdef UART_ARB_PKT_LOCK_EN
         if (req_last[pick_id]) begin
            lock    <= 1'b0;
            last_id <= pick_id;
         end else begin
            lock    <= 1'b1;
            lock_id <= pick_id;
         end
`else
         last_id  <= pick_id;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter; the bench also plays the transmitter.
// Expected order follows UART_ARB_PKT_LOCK_EN when that macro is defined.
module tb_uart_tx_arbiter;

   localparam int N = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [N*8-1:0]   req_data = '0;
   logic [N-1:0]     req_last = '0;
   logic [N-1:0]     req_ready;
   logic             tx_start;
   logic [7:0]       tx_data;
   logic             tx_busy = 1'b0;
   logic             tx_clear_req = 1'b0;
   logic [1:0]       grant_id;
   logic             arb_busy;

   uart_tx_arbiter #(.NUM_REQ(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .tx_clear_req(tx_clear_req),
      .grant_id    (grant_id),
      .arb_busy    (arb_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } item_t;

   typedef struct {
      int         id;
      logic [7:0] data;
   } exp_t;

   item_t  rq [N][$];
   exp_t   sb[$];
   int     served[$];
   int     checks = 0;
   int     errors = 0;

   // Reference model: 0 = arbiter free, 1 = start phase, 2 = waiting for completion.
   int     phase = 0;
   int     dly = 0;
   int     dur = 0;
   int     m_last = N - 1;
   int     m_lock_id = 0;
   bit     m_lock = 1'b0;
   int     pend_w = 0;
   bit     pend_acc = 1'b0;
   int     p_valid = 100;
   int     fixed_dly = -1;
   bit     force_stray = 1'b0;

   logic [N-1:0] exp_ready = '0;
   bit     exp_start = 1'b0;
   bit     exp_busy = 1'b0;
   int     start_len = 0;
   int     last_start_len = 0;
   bit     prev_start = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_item(input int r, input logic [7:0] d, input logic l);
      item_t it;
      it.data = d;
      it.last = l;
      rq[r].push_back(it);
   endtask

   function automatic bit work_left();
      bit any = 1'b0;
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) any = 1'b1;
      return any || pend_acc || (phase != 0);
   endfunction

   // Monitor: per-cycle control checks plus scoreboard pop on each new tx_start.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_start = 1'b0;
            start_len  = 0;
         end else begin
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("tx_start", 32'(tx_start), 32'(exp_start));
            check("arb_busy", 32'(arb_busy), 32'(exp_busy));
            if (tx_start && !prev_start) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_underflow: tx_start with data %0h but no byte expected", tx_data);
               end else begin
                  e = sb.pop_front();
                  check("tx_data", 32'(tx_data), 32'(e.data));
                  check("grant_id", 32'(grant_id), 32'(e.id));
                  served.push_back(int'(grant_id));
               end
            end
            if (tx_start) start_len++;
            else if (prev_start) begin
               last_start_len = start_len;
               start_len      = 0;
            end
            prev_start = tx_start;
         end
      end
   end

   // One clock of stimulus: advance the model over the edge, then drive the next cycle.
   task automatic step();
      int         w;
      logic [N-1:0] v;
      item_t      it;
      @(posedge clk);
      #1;
      if (phase == 0 && pend_acc) begin
         it = rq[pend_w].pop_front();
`ifdef UART_ARB_PKT_LOCK_EN
         if (it.last) begin
            m_lock = 1'b0;
            m_last = pend_w;
         end else begin
            m_lock    = 1'b1;
            m_lock_id = pend_w;
         end
`else
         m_last = pend_w;
`endif
         phase = 1;
         dly   = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 4));
      end else if (phase == 1 && tx_busy) begin
         phase = 2;
         dur   = int'($urandom_range(0, 5));
      end else if (phase == 2 && tx_clear_req) begin
         phase = 0;
      end
      pend_acc = 1'b0;

      tx_busy      = 1'b0;
      tx_clear_req = 1'b0;
      case (phase)
         0: tx_busy = 1'($urandom_range(0, 1));
         1: begin
            tx_busy = (dly == 0);
            if (dly > 0) dly--;
            tx_clear_req = force_stray | 1'($urandom_range(0, 1));
         end
         default: begin
            tx_busy      = 1'b1;
            tx_clear_req = (dur == 0);
            if (dur > 0) dur--;
         end
      endcase

      for (int i = 0; i < N; i++) begin
         v[i] = (rq[i].size() > 0) && ($urandom_range(0, 99) < p_valid);
         req_data[8*i +: 8] = v[i] ? rq[i][0].data : 8'($urandom);
         req_last[i]        = v[i] ? rq[i][0].last : 1'($urandom_range(0, 1));
      end
      req_valid = v;

      exp_start = (phase == 1);
      exp_busy  = (phase != 0);
      exp_ready = '0;
      if (phase == 0) begin
         w = -1;
         for (int k = 1; k <= N; k++) begin
            int jj = (m_last + k) % N;
            if (w < 0 && v[jj] && (!m_lock || jj == m_lock_id)) w = jj;
         end
         if (w >= 0) begin
            exp_ready[w] = 1'b1;
            pend_acc     = 1'b1;
            pend_w       = w;
            sb.push_back('{w, rq[w][0].data});
         end
      end
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      req_valid    = '0;
      req_last     = '0;
      tx_busy      = 1'b0;
      tx_clear_req = 1'b0;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      phase     = 0;
      pend_acc  = 1'b0;
      m_last    = N - 1;
      m_lock    = 1'b0;
      sb.delete();
      exp_ready = '0;
      exp_start = 1'b0;
      exp_busy  = 1'b0;
   endtask

   task automatic drain(input int budget);
      int c = 0;
      while (work_left() && c < budget) begin
         step();
         c++;
      end
      check("drain_in_budget", 32'(c < budget), 32'd1);
      check("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int c;
`ifdef UART_ARB_PKT_LOCK_EN
      int exp_pkt[5] = '{1, 1, 1, 0, 0};
`else
      int exp_pkt[5] = '{1, 0, 1, 0, 1};
`endif
      do_reset();
      @(negedge clk);
      check("reset_grant_id", 32'(grant_id), 32'd0);
      check("reset_tx_data", 32'(tx_data), 32'd0);

      // Single byte from requester 2.
      served.delete();
      push_item(2, 8'h41, 1'b1);
      drain(200);
      check("single_count", 32'(served.size()), 32'd1);
      if (served.size() > 0) check("single_id", 32'(served[0]), 32'd2);

      // Round-robin fairness with everyone valid continuously.
      do_reset();
      served.delete();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) push_item(i, 8'(8'h10 + i), 1'b1);
      drain(500);
      check("rr_count", 32'(served.size()), 32'd8);
      for (int k = 0; k < served.size() && k < 8; k++) check("rr_order", 32'(served[k]), 32'(k % N));

      // Start handshake: busy on the 5th start cycle, stray clears during start.
      do_reset();
      fixed_dly   = 4;
      force_stray = 1'b1;
      push_item(3, 8'h5a, 1'b1);
      drain(200);
      check("start_len", 32'(last_start_len), 32'd5);
      fixed_dly   = -1;
      force_stray = 1'b0;

      // Reset while waiting for completion.
      do_reset();
      push_item(2, 8'h77, 1'b1);
      c = 0;
      while (phase != 2 && c < 50) begin
         step();
         c++;
      end
      check("reached_wait", 32'(phase), 32'd2);
      do_reset();
      @(negedge clk);
      check("midrst_grant_id", 32'(grant_id), 32'd0);
      check("midrst_tx_data", 32'(tx_data), 32'd0);
      served.delete();
      for (int i = 0; i < N; i++) push_item(i, 8'(8'h60 + i), 1'b1);
      drain(500);
      if (served.size() > 0) check("midrst_first", 32'(served[0]), 32'd0);

      // Packet from requester 1 with requester 0 joining after the first byte.
      do_reset();
      served.delete();
      push_item(1, 8'hA0, 1'b0);
      push_item(1, 8'hA1, 1'b0);
      push_item(1, 8'hA2, 1'b1);
      c = 0;
      do begin
         step();
         c++;
      end while (!pend_acc && c < 20);
      push_item(0, 8'h50, 1'b1);
      push_item(0, 8'h51, 1'b1);
      drain(500);
      check("pkt_count", 32'(served.size()), 32'd5);
      for (int k = 0; k < served.size() && k < 5; k++) check("pkt_order", 32'(served[k]), 32'(exp_pkt[k]));

      // Randomized packets, valids and handshake timing.
      do_reset();
      p_valid = 70;
      for (int n = 0; n < 60; n++) begin
         int r   = int'($urandom_range(0, N - 1));
         int len = int'($urandom_range(1, 3));
         for (int b = 0; b < len; b++) push_item(r, 8'($urandom), 1'(b == len - 1));
      end
      drain(20000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
